// File: rtl/key_event_latch.sv
// key_event_latch: debounced push-button event flags read through a byte-wide CPU port with read-clear handshake.
// Define KEY_EVT_OVERFLOW_EN to build the sticky overflow flag on oOVF.
module key_event_latch #(
  parameter int N_KEYS          = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic [N_KEYS-1:0] iKEY,
  input  logic              iRD,
  output logic [7:0]        oDATA,
  output logic              oEVT,
  output logic              oOVF
);
  typedef enum logic [1:0] {REL, PW, PRS, RW} state_t;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  logic [N_KEYS-1:0] sync1, sync2, press, level, flags, flags_nx, mask;
  logic rd_q, rd_d, rd_rise, rd_fall;
  always_ff @(posedge iCLK or negedge iRST_N)
    if (!iRST_N) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= iKEY;
      sync2 <= sync1;
    end
  for (genvar k = 0; k < N_KEYS; k++) begin : g_key
    state_t st, st_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic s, pe;
    assign s = ~sync2[k];
    always_ff @(posedge iCLK or negedge iRST_N)
      if (!iRST_N) begin
        st  <= REL;
        cnt <= '0;
      end else begin
        st  <= st_nx;
        cnt <= cnt_nx;
      end
    always_comb begin
      st_nx  = st;
      cnt_nx = cnt;
      pe     = 1'b0;
      case (st)
        REL: if (s) begin
          st_nx  = PW;
          cnt_nx = '0;
        end
        PW: if (!s) st_nx = REL;
        else if (cnt == LAST) begin
          st_nx = PRS;
          pe    = 1'b1;
        end else cnt_nx = cnt + 1'b1;
        PRS: if (!s) begin
          st_nx  = RW;
          cnt_nx = '0;
        end
        RW: if (s) st_nx = PRS;
        else if (cnt == LAST) st_nx = REL;
        else cnt_nx = cnt + 1'b1;
        default: st_nx = REL;
      endcase
    end
    assign press[k] = pe;
    assign level[k] = (st == PRS) || (st == RW);
  end
  assign rd_rise = rd_q & ~rd_d;
  assign rd_fall = ~rd_q & rd_d;
  // a press landing on the clearing cycle survives: set wins over clear
  assign flags_nx = (flags & ~(rd_fall ? mask : '0)) | press;
  always_ff @(posedge iCLK or negedge iRST_N)
    if (!iRST_N) begin
      rd_q  <= 1'b0;
      rd_d  <= 1'b0;
      mask  <= '0;
      flags <= '0;
      oDATA <= '0;
      oEVT  <= 1'b0;
    end else begin
      rd_q  <= iRD;
      rd_d  <= rd_q;
      mask  <= rd_rise ? flags : mask;
      flags <= flags_nx;
      oDATA <= {4'(level), 4'(flags)};
      oEVT  <= |flags;
    end
`ifdef KEY_EVT_OVERFLOW_EN
  logic ovf;
  always_ff @(posedge iCLK or negedge iRST_N)
    if (!iRST_N) ovf <= 1'b0;
    else ovf <= (ovf & ~rd_fall) | (|(press & flags));
  assign oOVF = ovf;
`else
  assign oOVF = 1'b0;
`endif
endmodule

// File: tb/tb_key_event_latch.sv
// tb_key_event_latch: scoreboard bench for key_event_latch with a 4-cycle debounce.
module tb_key_event_latch;
  logic       iCLK = 1'b0;
  logic       iRST_N = 1'b0;
  logic [3:0] iKEY = 4'hF;
  logic       iRD = 1'b0;
  logic [7:0] oDATA;
  logic       oEVT, oOVF;
  logic [9:0] exp_q[$];
  logic [9:0] got, e;
  int n_cmp = 0, n_bad = 0;
`ifdef KEY_EVT_OVERFLOW_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  key_event_latch #(.N_KEYS(4), .DEBOUNCE_CYCLES(4), .CNT_W(4)) dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .iKEY(iKEY), .iRD(iRD),
    .oDATA(oDATA), .oEVT(oEVT), .oOVF(oOVF)
  );

  always #5 iCLK = ~iCLK;

  task automatic tick(input int n);
    repeat (n) @(posedge iCLK);
    #1;
  endtask

  task automatic read_pulse(input int len);
    iRD = 1'b1;
    tick(len);
    iRD = 1'b0;
    tick(4);
  endtask

  task automatic test_reset;
    iKEY = 4'h0;
    iRST_N = 1'b0;
    exp_q.push_back(10'h000);
    tick(3);
    e = exp_q.pop_front(); got = {oOVF, oEVT, oDATA}; n_cmp++;
    if (got !== e) begin n_bad++; $display("FAIL reset_hold: got %h expected %h", got, e); end
    iKEY = 4'hF;
    iRST_N = 1'b1;
    exp_q.push_back(10'h000);
    tick(10);
    e = exp_q.pop_front(); got = {oOVF, oEVT, oDATA}; n_cmp++;
    if (got !== e) begin n_bad++; $display("FAIL reset_release: got %h expected %h", got, e); end
  endtask

  task automatic test_clean_press;
    iKEY = 4'b1101;
    exp_q.push_back(10'h000);
    exp_q.push_back({2'b01, 8'h22});
    tick(7);
    e = exp_q.pop_front(); got = {oOVF, oEVT, oDATA}; n_cmp++;
    if (got !== e) begin n_bad++; $display("FAIL press_too_early: got %h expected %h", got, e); end
    tick(1);
    e = exp_q.pop_front(); got = {oOVF, oEVT, oDATA}; n_cmp++;
    if (got !== e) begin n_bad++; $display("FAIL press_latency: got %h expected %h", got, e); end
    iKEY = 4'hF;
    exp_q.push_back({2'b01, 8'h02});
    tick(10);
    e = exp_q.pop_front(); got = {oOVF, oEVT, oDATA}; n_cmp++;
    if (got !== e) begin n_bad++; $display("FAIL release_keeps_flag: got %h expected %h", got, e); end
    exp_q.push_back(10'h000);
    read_pulse(3);
    e = exp_q.pop_front(); got = {oOVF, oEVT, oDATA}; n_cmp++;
    if (got !== e) begin n_bad++; $display("FAIL press_read_clear: got %h expected %h", got, e); end
  endtask

  task automatic test_bounce;
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) iKEY[0] = ~iKEY[0];
      exp_q.push_back(10'h000);
      tick(1);
      e = exp_q.pop_front(); got = {oOVF, oEVT, oDATA}; n_cmp++;
      if (got !== e) begin n_bad++; $display("FAIL bounce_cycle%0d: got %h expected %h", i, got, e); end
    end
    iKEY = 4'hF;
    exp_q.push_back(10'h000);
    tick(12);
    e = exp_q.pop_front(); got = {oOVF, oEVT, oDATA}; n_cmp++;
    if (got !== e) begin n_bad++; $display("FAIL bounce_settle: got %h expected %h", got, e); end
  endtask

  task automatic test_read_clear;
    iKEY = 4'b1011;
    tick(9);
    iRD = 1'b1;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back({2'b01, 8'h44});
      tick(1);
      e = exp_q.pop_front(); got = {oOVF, oEVT, oDATA}; n_cmp++;
      if (got !== e) begin n_bad++; $display("FAIL read_hold%0d: got %h expected %h", i, got, e); end
    end
    iRD = 1'b0;
    exp_q.push_back({2'b00, 8'h40});
    tick(4);
    e = exp_q.pop_front(); got = {oOVF, oEVT, oDATA}; n_cmp++;
    if (got !== e) begin n_bad++; $display("FAIL read_clear_held: got %h expected %h", got, e); end
    iKEY = 4'hF;
    exp_q.push_back(10'h000);
    tick(10);
    e = exp_q.pop_front(); got = {oOVF, oEVT, oDATA}; n_cmp++;
    if (got !== e) begin n_bad++; $display("FAIL read_clear_released: got %h expected %h", got, e); end
  endtask

  task automatic test_press_during_read;
    iKEY = 4'b1110;
    tick(9);
    iKEY = 4'hF;
    exp_q.push_back({2'b01, 8'h01});
    tick(10);
    e = exp_q.pop_front(); got = {oOVF, oEVT, oDATA}; n_cmp++;
    if (got !== e) begin n_bad++; $display("FAIL pdr_setup: got %h expected %h", got, e); end
    iRD = 1'b1;
    tick(2);
    iKEY = 4'b0111;
    exp_q.push_back({2'b01, 8'h89});
    tick(10);
    e = exp_q.pop_front(); got = {oOVF, oEVT, oDATA}; n_cmp++;
    if (got !== e) begin n_bad++; $display("FAIL pdr_in_read: got %h expected %h", got, e); end
    iRD = 1'b0;
    exp_q.push_back({2'b01, 8'h88});
    tick(4);
    e = exp_q.pop_front(); got = {oOVF, oEVT, oDATA}; n_cmp++;
    if (got !== e) begin n_bad++; $display("FAIL pdr_after_fall: got %h expected %h", got, e); end
    iKEY = 4'hF;
    tick(10);
    exp_q.push_back(10'h000);
    read_pulse(2);
    e = exp_q.pop_front(); got = {oOVF, oEVT, oDATA}; n_cmp++;
    if (got !== e) begin n_bad++; $display("FAIL pdr_final_clear: got %h expected %h", got, e); end
  endtask

  task automatic test_reset_mid_debounce;
    iKEY = 4'b1011;
    tick(4);
    iRST_N = 1'b0;
    tick(1);
    iKEY = 4'hF;
    iRST_N = 1'b1;
    exp_q.push_back(10'h000);
    tick(12);
    e = exp_q.pop_front(); got = {oOVF, oEVT, oDATA}; n_cmp++;
    if (got !== e) begin n_bad++; $display("FAIL reset_mid_debounce: got %h expected %h", got, e); end
  endtask

  task automatic test_overflow;
    iKEY = 4'b1110;
    tick(9);
    iKEY = 4'hF;
    tick(10);
    iKEY = 4'b1110;
    exp_q.push_back({OVF_ON, 1'b1, 8'h11});
    tick(10);
    e = exp_q.pop_front(); got = {oOVF, oEVT, oDATA}; n_cmp++;
    if (got !== e) begin n_bad++; $display("FAIL overflow_set: got %h expected %h", got, e); end
    iKEY = 4'hF;
    exp_q.push_back({OVF_ON, 1'b1, 8'h01});
    tick(10);
    e = exp_q.pop_front(); got = {oOVF, oEVT, oDATA}; n_cmp++;
    if (got !== e) begin n_bad++; $display("FAIL overflow_sticky: got %h expected %h", got, e); end
    exp_q.push_back(10'h000);
    read_pulse(3);
    e = exp_q.pop_front(); got = {oOVF, oEVT, oDATA}; n_cmp++;
    if (got !== e) begin n_bad++; $display("FAIL overflow_clear: got %h expected %h", got, e); end
  endtask

  initial begin
    test_reset;
    test_clean_press;
    test_bounce;
    test_read_clear;
    test_press_during_read;
    test_reset_mid_debounce;
    test_overflow;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
